// File: rtl/cell_loader_pkg.sv
// ImageProcessingPkg: shared types for the image-processing datapath.
//   CELL_DIMENSION  - pixels per matrix row/column
//   pixel_t         - 24-bit RGB pixel (R [23:16], G [15:8], B [7:0])
//   pixelMatrix_t   - CELL_DIMENSION x CELL_DIMENSION pixels, indexed [row][col]
//   opcodes_t       - operation applied by the ImageProcessor
//   instruction_t   - two operand cells plus an opcode
//   loader_state_t  - cell_loader FSM states
package ImageProcessingPkg;

    localparam int CELL_DIMENSION = 4;

    typedef logic [23:0] pixel_t;

    typedef pixel_t [CELL_DIMENSION-1:0][CELL_DIMENSION-1:0] pixelMatrix_t;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        MUL = 3'd3,
        AVG = 3'd4,
        MAX = 3'd5,
        MIN = 3'd6,
        INV = 3'd7
    } opcodes_t;

    typedef struct packed {
        pixelMatrix_t cellA;
        pixelMatrix_t cellB;
        opcodes_t     opcode;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        ISSUE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/cell_loader.sv
// cell_loader: assembles an instruction from a pixel stream. The first
// CELL_DIM*CELL_DIM accepted pixels fill cellA in row-major order, the next
// CELL_DIM*CELL_DIM fill cellB, and the opcode is sampled with the very first
// pixel. The finished instruction is then held valid until consumed.
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-high
//   pixel_in     - RGB pixel
//   pixel_valid  - pixel_in holds a valid pixel
//   pixel_ready  - loader accepts pixel_in this cycle
//   opcode_in    - operation for the instruction being assembled
//   IW           - assembled instruction (cellA, cellB, opcode)
//   iw_valid     - IW is complete and stable
//   iw_ready     - downstream consumes IW this cycle
//   busy         - loader is not idle
module cell_loader
    import ImageProcessingPkg::*;
#(
    parameter int CELL_DIM = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [23:0]  pixel_in,
    input  logic         pixel_valid,
    output logic         pixel_ready,
    input  opcodes_t     opcode_in,
    output instruction_t IW,
    output logic         iw_valid,
    input  logic         iw_ready,
    output logic         busy
);

    // The matrix types are sized by the package constant, so the parameter
    // must agree with it.
    if (CELL_DIM != CELL_DIMENSION) begin : g_dim_check
        $error("cell_loader: CELL_DIM must equal ImageProcessingPkg::CELL_DIMENSION");
    end

    localparam int CW = (CELL_DIM > 1) ? $clog2(CELL_DIM) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(CELL_DIM - 1);

    loader_state_t state_reg;
    loader_state_t state_next;
    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    instruction_t  iw_reg;
    logic          pixel_xfer;
    logic          iw_xfer;
    logic          cell_last;

    always_comb begin
        state_next  = state_reg;
        pixel_ready = (state_reg != ISSUE);
        iw_valid    = (state_reg == ISSUE);
        busy        = (state_reg != IDLE);
        pixel_xfer  = pixel_valid && pixel_ready;
        iw_xfer     = iw_valid && iw_ready;
        cell_last   = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

        case (state_reg)
            IDLE: begin
                // A 1x1 cell would be complete after its first pixel.
                if (pixel_xfer) begin
                    state_next = cell_last ? LOAD_B : LOAD_A;
                end
            end
            LOAD_A: begin
                if (pixel_xfer && cell_last) begin
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                if (pixel_xfer && cell_last) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (iw_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters always point at the element the next accepted pixel writes,
    // so the first pixel in IDLE lands at [0][0] without a special case.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            iw_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (pixel_xfer) begin
                if (state_reg == IDLE) begin
                    iw_reg.opcode <= opcode_in;
                end
                if (state_reg == LOAD_B) begin
                    iw_reg.cellB[row_reg][col_reg] <= pixel_in;
                end else begin
                    iw_reg.cellA[row_reg][col_reg] <= pixel_in;
                end
                if (cell_last) begin
                    row_reg <= '0;
                    col_reg <= '0;
                end else if (col_reg == LAST_IDX) begin
                    col_reg <= '0;
                    row_reg <= row_reg + CW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
            end
        end
    end

    assign IW = iw_reg;

endmodule

// File: tb/tb_cell_loader.sv
module tb_cell_loader;
    import ImageProcessingPkg::*;

    localparam int D = CELL_DIMENSION;
    localparam int N = D * D;

    logic         clk = 1'b0;
    logic         reset;
    logic [23:0]  pixel_in;
    logic         pixel_valid;
    logic         pixel_ready;
    opcodes_t     opcode_in;
    instruction_t IW;
    logic         iw_valid;
    logic         iw_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    cell_loader #(.CELL_DIM(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .opcode_in   (opcode_in),
        .IW          (IW),
        .iw_valid    (iw_valid),
        .iw_ready    (iw_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [799:0] act, input logic [799:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Counts accepted pixels of the current instruction; once 2*N have been
    // taken the instruction is pending until the consumer takes it, and no
    // pixel is accepted meanwhile.
    int       m_cnt;
    bit       m_pend;
    pixel_t   m_a [N];
    pixel_t   m_b [N];
    opcodes_t m_op;

    function automatic instruction_t model_iw();
        instruction_t t;
        t = '0;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                t.cellA[r][c] = m_a[r*D + c];
                t.cellB[r][c] = m_b[r*D + c];
            end
        end
        t.opcode = m_op;
        return t;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  = 0;
            m_pend = 0;
            m_op   = NOP;
            for (int i = 0; i < N; i++) begin
                m_a[i] = '0;
                m_b[i] = '0;
            end
        end else if (m_pend) begin
            if (iw_ready) begin
                m_pend = 0;
                $display("instruction taken: op=%s a00=%06h b00=%06h", m_op.name(), m_a[0], m_b[0]);
            end
        end else if (pixel_valid) begin
            if (m_cnt == 0) m_op = opcode_in;
            if (m_cnt < N) m_a[m_cnt] = pixel_in;
            else           m_b[m_cnt - N] = pixel_in;
            m_cnt++;
            if (m_cnt == 2*N) begin
                m_cnt  = 0;
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("pixel_ready", pixel_ready, !m_pend);
        check("iw_valid", iw_valid, m_pend);
        check("busy", busy, (m_cnt != 0) || m_pend);
        if (m_pend) check("IW", IW, model_iw());
        if (reset)  check("IW_in_reset", IW, '0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    instruction_t saved;

    initial begin
        reset       = 1'b1;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        opcode_in   = NOP;
        iw_ready    = 1'b0;
        repeat (3) tick();
        check("reset_IW", IW, '0);
        check("reset_iw_valid", iw_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", pixel_ready, 1'b1);

        // Back-to-back lime then blue, opcode ADD on the first pixel only.
        for (int i = 0; i < 2*N; i++) begin
            pixel_valid = 1'b1;
            pixel_in    = (i < N) ? 24'h00FF00 : 24'h0000FF;
            opcode_in   = (i == 0) ? ADD : SUB;
            tick();
            check("iw_valid_latency", iw_valid, (i == 2*N - 1));
        end
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                check("lime_cellA", IW.cellA[r][c], 24'h00FF00);
                check("blue_cellB", IW.cellB[r][c], 24'h0000FF);
            end
        end
        check("opcode_add", IW.opcode, ADD);

        // Stall in ISSUE with a red pixel waiting.
        pixel_in = 24'hFF0000;
        saved    = IW;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ready", pixel_ready, 1'b0);
            check("stall_valid", iw_valid, 1'b1);
            check("stall_IW", IW, saved);
        end
        iw_ready = 1'b1;
        tick();
        iw_ready = 1'b0;
        check("post_issue_valid", iw_valid, 1'b0);
        check("post_issue_busy", busy, 1'b0);
        tick();
        check("red_at_00", IW.cellA[0][0], 24'hFF0000);
        check("red_busy", busy, 1'b1);

        // 19 more transfers (20 total), then reset mid-load.
        for (int i = 0; i < 19; i++) begin
            pixel_in = 24'($urandom);
            tick();
        end
        reset = 1'b1;
        #1;
        check("midload_reset_valid", iw_valid, 1'b0);
        check("midload_reset_IW", IW, '0);
        check("midload_reset_busy", busy, 1'b0);
        tick();
        reset = 1'b0;

        // 32 white pixels; opcode changes after the first one.
        for (int i = 0; i < 2*N; i++) begin
            pixel_in  = 24'hFFFFFF;
            opcode_in = (i == 0) ? MUL : opcodes_t'($urandom_range(0, 7));
            tick();
        end
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                check("white_cellA", IW.cellA[r][c], 24'hFFFFFF);
                check("white_cellB", IW.cellB[r][c], 24'hFFFFFF);
            end
        end
        check("opcode_first_sample", IW.opcode, MUL);
        pixel_valid = 1'b0;
        iw_ready    = 1'b1;
        tick();
        iw_ready    = 1'b0;

        // Counting pixels with pixel_valid toggling every other cycle.
        for (int k = 0; k < 4*N; k++) begin
            pixel_valid = (k % 2 == 0);
            pixel_in    = 24'(k / 2);
            opcode_in   = (k == 0) ? AVG : INV;
            tick();
        end
        pixel_valid = 1'b0;
        check("count_valid", iw_valid, 1'b1);
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                check("count_cellA", IW.cellA[r][c], 24'(4*r + c));
                check("count_cellB", IW.cellB[r][c], 24'(16 + 4*r + c));
            end
        end
        check("count_opcode", IW.opcode, AVG);
        iw_ready = 1'b1;
        tick();
        iw_ready = 1'b0;

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            pixel_valid = ($urandom_range(0, 3) != 0);
            pixel_in    = 24'($urandom);
            opcode_in   = opcodes_t'($urandom_range(0, 7));
            iw_ready    = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset       = 1'b0;
        pixel_valid = 1'b0;
        iw_ready    = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
